// File: rtl/uart_cmd_sequencer_if.sv
// Byte-in / register-write-out bundle between the UART receiver side and the command sequencer.
// The receiver side (master) drives the byte strobe. The sequencer (slave) drives the write port and the status pulses.
// Port names keep the receiver/register-file naming already used in the codebase.
interface uart_cmd_if;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic       o_wr_en;
    logic [7:0] o_wr_addr;
    logic [7:0] o_wr_data;
    logic       o_busy;
    logic       o_frame_ok;
    logic       o_err_checksum;
    logic       o_err_len;
    logic       o_err_timeout;
    logic       o_overrun;

    modport master (
        output i_rx_data, i_rx_valid,
        input  o_wr_en, o_wr_addr, o_wr_data, o_busy, o_frame_ok,
               o_err_checksum, o_err_len, o_err_timeout, o_overrun
    );

    modport slave (
        input  i_rx_data, i_rx_valid,
        output o_wr_en, o_wr_addr, o_wr_data, o_busy, o_frame_ok,
               o_err_checksum, o_err_len, o_err_timeout, o_overrun
    );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// Parses SYNC/ADDR/LEN/PAYLOAD/CHK frames, buffers the payload, and replays it as burst register writes once the XOR check passes.
// Latency: the first write comes one cycle after CHK is accepted, with one write per cycle after that. o_frame_ok follows the last write.
// Backpressure: none is possible on the byte stream. Bytes arriving during COMMIT are dropped and flagged with o_overrun.
module uart_cmd_sequencer #(
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 668220,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic     clk,
    input  logic     r_reset,
    uart_cmd_if.slave bus
);
    localparam int              CW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]   TERM      = CW'(TIMEOUT_CYCLES - 1);
    localparam int              IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_LEN     = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;
    localparam logic [2:0] S_COMMIT  = 3'd5;

    logic [2:0]    state, state_nxt;
    logic [7:0]    base, len, idx, chk;
    logic [CW-1:0] cnt;
    logic [7:0]    mem [2**IW];

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       counting, timeout_hit;
    logic       len_err_n, chk_err_n, to_n, ok_n, ovr_n;

    logic       wr_en, busy, frame_ok, err_checksum, err_len, err_timeout, overrun;
    logic [7:0] wr_addr, wr_data;

    assign rx_data  = bus.i_rx_data;
    assign rx_valid = bus.i_rx_valid;

    // The inter-byte watchdog only runs while a frame is being received, not in IDLE or COMMIT.
    assign counting    = (state == S_ADDR) || (state == S_LEN) ||
                         (state == S_PAYLOAD) || (state == S_CHECK);
    // A byte that lands on the terminal count wins over the timeout.
    assign timeout_hit = counting && !rx_valid && (cnt == TERM);

    // Next state and one-cycle status flags. The timeout overrides any other transition.
    always_comb begin
        state_nxt = state;
        len_err_n = 1'b0;
        chk_err_n = 1'b0;
        to_n      = 1'b0;
        ok_n      = 1'b0;
        ovr_n     = 1'b0;
        case (state)
            S_IDLE:    if (rx_valid && rx_data == SYNC_BYTE) state_nxt = S_ADDR;
            S_ADDR:    if (rx_valid) state_nxt = S_LEN;
            S_LEN: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                        state_nxt = S_IDLE;
                        len_err_n = 1'b1;
                    end else begin
                        state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: if (rx_valid && idx == len - 8'd1) state_nxt = S_CHECK;
            S_CHECK: begin
                if (rx_valid) begin
                    if (rx_data == chk) begin
                        state_nxt = S_COMMIT;
                    end else begin
                        state_nxt = S_IDLE;
                        chk_err_n = 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                ovr_n = rx_valid;
                if (idx == len) begin
                    state_nxt = S_IDLE;
                    ok_n      = 1'b1;
                end
            end
            default:   state_nxt = S_IDLE;
        endcase
        if (timeout_hit) begin
            state_nxt = S_IDLE;
            to_n      = 1'b1;
        end
    end

    // Frame state, field capture, running XOR, watchdog and registered outputs.
    always_ff @(posedge clk) begin
        if (r_reset) begin
            state        <= S_IDLE;
            base         <= 8'd0;
            len          <= 8'd0;
            idx          <= 8'd0;
            chk          <= 8'd0;
            cnt          <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= 8'd0;
            wr_data      <= 8'd0;
            busy         <= 1'b0;
            frame_ok     <= 1'b0;
            err_checksum <= 1'b0;
            err_len      <= 1'b0;
            err_timeout  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_nxt;
            busy         <= (state_nxt != S_IDLE);
            frame_ok     <= ok_n;
            err_checksum <= chk_err_n;
            err_len      <= len_err_n;
            err_timeout  <= to_n;
            overrun      <= ovr_n;
            wr_en        <= 1'b0;

            if (rx_valid || !counting || timeout_hit) cnt <= '0;
            else                                      cnt <= cnt + 1'b1;

            case (state)
                S_ADDR: if (rx_valid) begin
                    base <= rx_data;
                    chk  <= rx_data;
                end
                S_LEN: if (rx_valid) begin
                    len <= rx_data;
                    chk <= chk ^ rx_data;
                    idx <= 8'd0;
                end
                S_PAYLOAD: if (rx_valid) begin
                    chk <= chk ^ rx_data;
                    idx <= idx + 8'd1;
                end
                S_CHECK: if (state_nxt == S_COMMIT) begin
                    // The first write is issued on the checksum edge itself, so no bubble occurs before the burst.
                    wr_en   <= 1'b1;
                    wr_addr <= base;
                    wr_data <= mem[{IW{1'b0}}];
                    idx     <= 8'd1;
                end
                S_COMMIT: if (idx != len) begin
                    wr_en   <= 1'b1;
                    wr_addr <= base + idx;
                    wr_data <= mem[idx[IW-1:0]];
                    idx     <= idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Payload buffer. Its contents are only read after a full frame has rewritten them, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && rx_valid) mem[idx[IW-1:0]] <= rx_data;
    end

    assign bus.o_wr_en        = wr_en;
    assign bus.o_wr_addr      = wr_addr;
    assign bus.o_wr_data      = wr_data;
    assign bus.o_busy         = busy;
    assign bus.o_frame_ok     = frame_ok;
    assign bus.o_err_checksum = err_checksum;
    assign bus.o_err_len      = err_len;
    assign bus.o_err_timeout  = err_timeout;
    assign bus.o_overrun      = overrun;
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Bench for uart_cmd_sequencer. Scenario tasks compare the DUT against frame-level expectations.
// A negedge monitor logs every write and pulse with its cycle stamp.
// The timeout parameter is shortened so the timeout scenarios run quickly.
module tb_uart_cmd_sequencer;
    localparam int         MAXL = 16;
    localparam int         TO   = 20;
    localparam logic [7:0] SYNC = 8'hA5;

    logic clk = 1'b0;
    logic r_reset;
    uart_cmd_if bus();

    uart_cmd_sequencer #(.MAX_LEN(MAXL), .TIMEOUT_CYCLES(TO), .SYNC_BYTE(SYNC)) dut (
        .clk(clk), .r_reset(r_reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int last_edge;
    logic [7:0] pl [256];

    int wa_q[$], wd_q[$], wc_q[$], ok_q[$], okb_q[$], ec_q[$], ecb_q[$], el_q[$], et_q[$], etb_q[$], ov_q[$];

    always @(negedge clk) begin
        if (bus.o_wr_en === 1'b1) begin
            wa_q.push_back(int'(bus.o_wr_addr));
            wd_q.push_back(int'(bus.o_wr_data));
            wc_q.push_back(cyc);
        end
        if (bus.o_frame_ok === 1'b1)     begin ok_q.push_back(cyc); okb_q.push_back(int'(bus.o_busy)); end
        if (bus.o_err_checksum === 1'b1) begin ec_q.push_back(cyc); ecb_q.push_back(int'(bus.o_busy)); end
        if (bus.o_err_len === 1'b1)      el_q.push_back(cyc);
        if (bus.o_err_timeout === 1'b1)  begin et_q.push_back(cyc); etb_q.push_back(int'(bus.o_busy)); end
        if (bus.o_overrun === 1'b1)      ov_q.push_back(cyc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); ok_q.delete(); okb_q.delete();
        ec_q.delete(); ecb_q.delete(); el_q.delete(); et_q.delete(); etb_q.delete(); ov_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_rx_valid = 1'b0;
        last_edge      = cyc;
    endtask

    function automatic int pick_gap(input int g);
        return (g >= 0) ? g : int'($urandom_range(0, 3));
    endfunction

    function automatic logic [7:0] model_chk(input logic [7:0] a, input logic [7:0] l);
        logic [7:0] x;
        x = a ^ l;
        for (int k = 0; k < int'(l); k++) x = x ^ pl[k];
        return x;
    endfunction

    // Sends one frame. For an illegal LEN, the byte stream stops after LEN. t_end is the edge that accepted the last byte.
    task automatic send_frame(input string name, input logic [7:0] addr, input logic [7:0] len,
                              input logic [7:0] chk, input int gap, output int t_end);
        send_byte(SYNC);
        checks++;
        if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_sync got %b exp 1", name, bus.o_busy); end
        idle(pick_gap(gap)); send_byte(addr);
        idle(pick_gap(gap)); send_byte(len);
        if (len != 8'd0 && int'(len) <= MAXL) begin
            for (int k = 0; k < int'(len); k++) begin idle(pick_gap(gap)); send_byte(pl[k]); end
            idle(pick_gap(gap)); send_byte(chk);
        end
        t_end = last_edge;
    endtask

    // Waits for the frame to drain, then compares the logged activity with what the frame rules predict.
    task automatic check_outcome(input string name, input logic [7:0] addr, input logic [7:0] len,
                                 input logic [7:0] chk, input int t, input int ov_cyc);
        bit len_bad, good, ck_bad;
        int n_exp;
        len_bad = (len == 8'd0) || (int'(len) > MAXL);
        good    = !len_bad && (chk == model_chk(addr, len));
        ck_bad  = !len_bad && !good;
        n_exp   = good ? int'(len) : 0;
        idle(MAXL + 4);
        checks++;
        if (wa_q.size() != n_exp) begin errors++; $display("FAIL %s wr_count got %0d exp %0d", name, wa_q.size(), n_exp); end
        for (int k = 0; k < n_exp && k < wa_q.size(); k++) begin
            checks++;
            if (wa_q[k] != ((int'(addr) + k) % 256) || wd_q[k] != int'(pl[k]) || wc_q[k] != t + k) begin
                errors++;
                $display("FAIL %s write%0d got a=%h d=%h c=%0d exp a=%h d=%h c=%0d", name, k, wa_q[k], wd_q[k], wc_q[k],
                         (int'(addr) + k) % 256, pl[k], t + k);
            end
        end
        checks++;
        if (ok_q.size() != int'(good)) begin errors++; $display("FAIL %s frame_ok_count got %0d exp %0d", name, ok_q.size(), good); end
        if (good && ok_q.size() > 0) begin
            checks++;
            if (ok_q[0] != t + int'(len) || okb_q[0] != 0) begin
                errors++; $display("FAIL %s frame_ok_timing got c=%0d busy=%0d exp c=%0d busy=0", name, ok_q[0], okb_q[0], t + int'(len));
            end
        end
        checks++;
        if (ec_q.size() != int'(ck_bad)) begin errors++; $display("FAIL %s err_checksum_count got %0d exp %0d", name, ec_q.size(), ck_bad); end
        if (ck_bad && ec_q.size() > 0) begin
            checks++;
            if (ec_q[0] != t || ecb_q[0] != 0) begin
                errors++; $display("FAIL %s err_checksum_timing got c=%0d busy=%0d exp c=%0d busy=0", name, ec_q[0], ecb_q[0], t);
            end
        end
        checks++;
        if (el_q.size() != int'(len_bad)) begin errors++; $display("FAIL %s err_len_count got %0d exp %0d", name, el_q.size(), len_bad); end
        if (len_bad && el_q.size() > 0) begin
            checks++;
            if (el_q[0] != t) begin errors++; $display("FAIL %s err_len_timing got %0d exp %0d", name, el_q[0], t); end
        end
        checks++;
        if (et_q.size() != 0) begin errors++; $display("FAIL %s err_timeout_count got %0d exp 0", name, et_q.size()); end
        checks++;
        if (ov_cyc < 0 ? ov_q.size() != 0 : (ov_q.size() != 1 || ov_q[0] != ov_cyc)) begin
            errors++; $display("FAIL %s overrun got count=%0d exp cycle %0d", name, ov_q.size(), ov_cyc);
        end
    endtask

    task automatic run_frame(input string name, input logic [7:0] addr, input logic [7:0] len,
                             input logic [7:0] chk, input int gap);
        int t;
        clear_mon();
        send_frame(name, addr, len, chk, gap, t);
        check_outcome(name, addr, len, chk, t, -1);
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_busy, bus.o_frame_ok, bus.o_err_checksum,
             bus.o_err_len, bus.o_err_timeout, bus.o_overrun} !== 23'd0) begin
            errors++;
            $display("FAIL %s outputs got en=%b a=%h d=%h busy=%b ok=%b ec=%b el=%b et=%b ov=%b exp all 0", name,
                     bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_busy, bus.o_frame_ok,
                     bus.o_err_checksum, bus.o_err_len, bus.o_err_timeout, bus.o_overrun);
        end
    endtask

    task automatic test_reset();
        r_reset = 1'b1;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        idle(3);
        check_all_zero("reset");
        r_reset = 1'b0;
        idle(2);
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_good_frame();
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        run_frame("good", 8'h10, 8'd3, model_chk(8'h10, 8'd3), -1);
    endtask

    task automatic test_bad_checksum();
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        run_frame("badchk", 8'h10, 8'd3, 8'h12, -1);
    endtask

    task automatic test_len_errors();
        run_frame("len0", 8'h20, 8'd0, 8'h00, -1);
        run_frame("len17", 8'h20, 8'(MAXL + 1), 8'h00, -1);
        for (int k = 0; k < MAXL; k++) pl[k] = 8'($urandom);
        run_frame("after_len_err_maxlen", 8'h30, 8'(MAXL), model_chk(8'h30, 8'(MAXL)), -1);
    endtask

    task automatic test_timeout();
        int t;
        clear_mon();
        send_byte(SYNC);
        send_byte(8'h20);
        t = last_edge;
        idle(TO + 10);
        checks++;
        if (et_q.size() != 1 || et_q[0] != t + TO || etb_q[0] != 0) begin
            errors++; $display("FAIL timeout got count=%0d exp one pulse at %0d with busy 0", et_q.size(), t + TO);
        end
        checks++;
        if (wa_q.size() + ok_q.size() + ec_q.size() + el_q.size() != 0) begin
            errors++; $display("FAIL timeout_side_effects got %0d events exp 0", wa_q.size() + ok_q.size() + ec_q.size() + el_q.size());
        end
        pl[0] = 8'h44; pl[1] = 8'h55;
        run_frame("terminal_count_byte", 8'h60, 8'd2, model_chk(8'h60, 8'd2), TO - 1);
    endtask

    task automatic test_wrap_sync();
        pl[0] = 8'hA5; pl[1] = 8'h01; pl[2] = 8'h02;
        run_frame("wrap_sync", 8'hFE, 8'd3, model_chk(8'hFE, 8'd3), -1);
    endtask

    task automatic test_overrun();
        int t;
        clear_mon();
        for (int k = 0; k < 4; k++) pl[k] = 8'($urandom);
        send_frame("overrun", 8'h40, 8'd4, model_chk(8'h40, 8'd4), 0, t);
        send_byte(SYNC);
        check_outcome("overrun", 8'h40, 8'd4, model_chk(8'h40, 8'd4), t, t + 1);
        checks++;
        if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL overrun_dropped_byte busy got %b exp 0", bus.o_busy); end
    endtask

    task automatic test_reset_mid_commit();
        int t;
        clear_mon();
        pl[0] = 8'h5A; pl[1] = 8'h6B; pl[2] = 8'h7C;
        send_frame("rst_commit", 8'h80, 8'd3, model_chk(8'h80, 8'd3), 0, t);
        idle(1);
        r_reset = 1'b1;
        idle(1);
        check_all_zero("reset_mid_commit");
        r_reset = 1'b0;
        idle(5);
        checks++;
        if (wa_q.size() != 2 || ok_q.size() != 0) begin
            errors++; $display("FAIL reset_mid_commit_writes got w=%0d ok=%0d exp w=2 ok=0", wa_q.size(), ok_q.size());
        end
        pl[0] = 8'h9D;
        run_frame("after_reset", 8'h81, 8'd1, model_chk(8'h81, 8'd1), -1);
    endtask

    task automatic test_back_to_back();
        int ta, tb;
        clear_mon();
        pl[0] = 8'hC1; pl[1] = 8'hC2;
        send_frame("b2b_a", 8'h70, 8'd2, model_chk(8'h70, 8'd2), 0, ta);
        idle(2);
        send_frame("b2b_b", 8'h90, 8'd2, model_chk(8'h90, 8'd2), 0, tb);
        idle(MAXL + 4);
        checks++;
        if (wa_q.size() != 4 || ok_q.size() != 2) begin
            errors++; $display("FAIL b2b_counts got w=%0d ok=%0d exp w=4 ok=2", wa_q.size(), ok_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (wa_q[k] != (k < 2 ? 8'h70 + k : 8'h90 + k - 2) || wd_q[k] != int'(pl[k % 2]) ||
                    wc_q[k] != (k < 2 ? ta + k : tb + k - 2)) begin
                    errors++; $display("FAIL b2b_write%0d got a=%h d=%h c=%0d", k, wa_q[k], wd_q[k], wc_q[k]);
                end
            end
            checks++;
            if (ok_q[0] != ta + 2 || ok_q[1] != tb + 2) begin
                errors++; $display("FAIL b2b_frame_ok got %0d,%0d exp %0d,%0d", ok_q[0], ok_q[1], ta + 2, tb + 2);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] addr, len, chk, g;
        int t, r;
        for (int it = 0; it < 40; it++) begin
            clear_mon();
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom);
                if (g == SYNC) g = 8'h00;
                send_byte(g);
            end
            addr = 8'($urandom);
            r = $urandom_range(0, 9);
            if (r == 0)      len = 8'd0;
            else if (r == 1) len = 8'(MAXL + 1 + $urandom_range(0, 254 - MAXL));
            else             len = 8'($urandom_range(1, MAXL));
            for (int k = 0; k < MAXL; k++) pl[k] = 8'($urandom);
            chk = model_chk(addr, len);
            if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
            send_frame("random", addr, len, chk, -1, t);
            check_outcome("random", addr, len, chk, t, -1);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_len_errors();
        test_timeout();
        test_wrap_sync();
        test_overrun();
        test_reset_mid_commit();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
